ofdm_cp_inserter: RTL and testbench
===================================

Name: ofdm_cp_inserter

Overview:
AXI-Stream block that sits directly downstream of the ifft core's M_AXIS_DATA port in the OFDM transmit chain. It buffers one complete time-domain symbol of NFFT samples. It then re-emits the last CP_LEN samples as the cyclic prefix, followed by the full symbol. It also reports frame-framing errors as single-cycle event pulses, matching the core's event_* style.

Parameters:
DATA_W, 32, sample width (packed {4'b0, IM[11:0], 4'b0, RE[11:0]}); passed through untouched.
NFFT, 64, symbol length in samples; power of two, 8..1024.
CP_LEN, 16, cyclic prefix length; legal range 0..NFFT-1.

Ports:
aclk  in  1  clock, all logic rising-edge.
areset  in  1  asynchronous, active-high reset.
S_AXIS_DATA_tdata  in  DATA_W  input sample from ifft.
S_AXIS_DATA_tvalid  in  1  input sample valid.
S_AXIS_DATA_tlast  in  1  input end of symbol.
S_AXIS_DATA_tready  out  1  block can accept a sample.
M_AXIS_DATA_tdata  out  DATA_W  output sample (CP + symbol).
M_AXIS_DATA_tvalid  out  1  output sample valid.
M_AXIS_DATA_tlast  out  1  marks the last sample of the CP+symbol frame.
M_AXIS_DATA_tready  in  1  downstream accepts.
event_frame_started  out  1  1-cycle pulse when sample 0 of a symbol is accepted.
event_tlast_missing  out  1  1-cycle pulse when sample NFFT-1 is accepted without tlast.
event_tlast_unexpected  out  1  1-cycle pulse when tlast arrives on sample index < NFFT-1.

Behaviour:
- Storage: NFFT x DATA_W buffer with asynchronous read; wr_idx and rd_idx are log2(NFFT) bits wide.
- Reset values: FSM=FILL, wr_idx=0, rd_idx=0, S_AXIS_DATA_tready=1, M_AXIS_DATA_tvalid=0, M_AXIS_DATA_tlast=0, all event_* outputs=0. M_AXIS_DATA_tdata is don't-care while tvalid=0.
- Transfer rule: a transfer occurs on a rising edge where tvalid&&tready=1. M_AXIS_DATA_tvalid, tdata and tlast hold stable until accepted. tvalid never drops without a transfer, except on areset.
- FSM state FILL:
  - tready=1, M_AXIS_DATA_tvalid=0.
  - On each accepted input: mem[wr_idx]<=tdata, then wr_idx++.
  - wr_idx==0 on accept -> event_frame_started pulses on the next cycle.
  - Input tlast with wr_idx<NFFT-1 -> event_tlast_unexpected pulses. The partial symbol is dropped, wr_idx<=0, and the FSM stays in FILL.
  - wr_idx==NFFT-1 accepted -> wr_idx<=0.
    - No tlast on that sample -> event_tlast_missing pulses; the symbol is still treated as complete.
    - rd_idx<=NFFT-CP_LEN.
    - Next state is EMIT_CP, or EMIT_BODY with rd_idx<=0 if CP_LEN==0.
- FSM state EMIT_CP:
  - tready=0, M_AXIS_DATA_tvalid=1, tdata=mem[rd_idx], tlast=0.
  - On output accept: rd_idx++. When rd_idx==NFFT-1 is accepted, rd_idx wraps to 0 and the FSM moves to EMIT_BODY.
- FSM state EMIT_BODY:
  - tready=0, tvalid=1, tdata=mem[rd_idx], tlast=(rd_idx==NFFT-1).
  - On output accept: rd_idx++.
  - When the tlast sample is accepted: rd_idx<=0, the FSM returns to FILL, and tready=1 on the following cycle.
- Latency: the first CP sample is valid the cycle after the last input sample is accepted. Output frame length is exactly NFFT+CP_LEN transfers.
- Throughput: fill and emit do not overlap. Input is back-pressured (tready=0) for the whole emit phase.
- Input tvalid gaps in FILL and output tready gaps in EMIT_* stall only the affected index; no data is lost or duplicated.
- Event pulses are registered, exactly one cycle wide, and never repeat for the same sample. event_frame_started and event_tlast_missing may assert in the same cycle only when NFFT==1, which is illegal.
- Reset mid-operation: areset forces the reset values immediately, without waiting for a clock edge. The partial input symbol or partially emitted frame is abandoned and never completed. Buffer contents are not cleared.

Test Plan:
- NFFT=8, CP_LEN=2, tready=1; input samples 0..7 with tlast on 7 -> output 6,7,0,1,2,3,4,5,6,7; tlast only on the final 7; 10 transfers; first valid one cycle after input 7 is accepted; event_frame_started pulses once.
- Same setup with M_AXIS_DATA_tready toggling 1,0,1,0... and input tvalid gaps every 3rd cycle -> identical output sequence, no drops or duplicates, S_AXIS_DATA_tready=0 throughout emit.
- Input tlast on sample index 4 (values 0..4), then a full frame 10..17 -> event_tlast_unexpected pulses once; output is 16,17,10..17; the truncated data never appears.
- Frame 0..7 with no tlast -> event_tlast_missing pulses once; output is still 6,7,0..7 with tlast on the final sample.
- CP_LEN=0 -> output 0..7 only, tlast on 7, EMIT_CP never entered.
- Assert areset during the 4th output beat -> M_AXIS_DATA_tvalid=0 immediately and S_AXIS_DATA_tready=1; the next frame 20..27 emits 26,27,20..27 correctly.

Source files
------------

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter for the OFDM transmit chain: buffers one IFFT symbol,
// then replays its tail as the prefix followed by the whole symbol.
module ofdm_cp_inserter #(
   parameter int DATA_W = 32,
   parameter int NFFT   = 64,
   parameter int CP_LEN = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] S_AXIS_DATA_tdata,
   input  logic              S_AXIS_DATA_tvalid,
   input  logic              S_AXIS_DATA_tlast,
   output logic              S_AXIS_DATA_tready,
   output logic [DATA_W-1:0] M_AXIS_DATA_tdata,
   output logic              M_AXIS_DATA_tvalid,
   output logic              M_AXIS_DATA_tlast,
   input  logic              M_AXIS_DATA_tready,
   output logic              event_frame_started,
   output logic              event_tlast_missing,
   output logic              event_tlast_unexpected
);

   localparam int IDX_W = $clog2(NFFT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);
   localparam logic [IDX_W-1:0] CP_START = IDX_W'(NFFT - CP_LEN);

   typedef enum logic [1:0] {FILL, EMIT_CP, EMIT_BODY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic              ev_start_q, ev_start_d;
   logic              ev_missing_q, ev_missing_d;
   logic              ev_unexp_q, ev_unexp_d;
   logic [DATA_W-1:0] mem_q [NFFT];
   logic              s_acc, m_acc;

   // Handshake outputs decode straight from the state register so that an
   // asynchronous reset drops tvalid and raises tready without a clock edge.
   assign S_AXIS_DATA_tready     = (state_q == FILL);
   assign M_AXIS_DATA_tvalid     = (state_q != FILL);
   assign M_AXIS_DATA_tdata      = mem_q[rd_idx_q];
   assign M_AXIS_DATA_tlast      = (state_q == EMIT_BODY) && (rd_idx_q == LAST_IDX);
   assign event_frame_started    = ev_start_q;
   assign event_tlast_missing    = ev_missing_q;
   assign event_tlast_unexpected = ev_unexp_q;

   assign s_acc = S_AXIS_DATA_tvalid && S_AXIS_DATA_tready;
   assign m_acc = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;

   always_comb begin
      state_d      = state_q;
      wr_idx_d     = wr_idx_q;
      rd_idx_d     = rd_idx_q;
      ev_start_d   = 1'b0;
      ev_missing_d = 1'b0;
      ev_unexp_d   = 1'b0;
      case (state_q)
         FILL: begin
            if (s_acc) begin
               ev_start_d = (wr_idx_q == '0);
               if (wr_idx_q == LAST_IDX) begin
                  // A missing tlast is reported but the symbol is still complete.
                  wr_idx_d     = '0;
                  ev_missing_d = !S_AXIS_DATA_tlast;
                  if (CP_LEN == 0) begin
                     rd_idx_d = '0;
                     state_d  = EMIT_BODY;
                  end else begin
                     rd_idx_d = CP_START;
                     state_d  = EMIT_CP;
                  end
               end else if (S_AXIS_DATA_tlast) begin
                  ev_unexp_d = 1'b1;
                  wr_idx_d   = '0;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         EMIT_CP: begin
            if (m_acc) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = '0;
                  state_d  = EMIT_BODY;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         EMIT_BODY: begin
            if (m_acc) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = '0;
                  state_d  = FILL;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= FILL;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         ev_start_q   <= 1'b0;
         ev_missing_q <= 1'b0;
         ev_unexp_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_idx_q     <= wr_idx_d;
         rd_idx_q     <= rd_idx_d;
         ev_start_q   <= ev_start_d;
         ev_missing_q <= ev_missing_d;
         ev_unexp_q   <= ev_unexp_d;
      end
   end

   // Symbol buffer is deliberately not reset; stale contents are never read
   // before being overwritten by a fresh fill.
   always_ff @(posedge aclk) begin
      if (s_acc) mem_q[wr_idx_q] <= S_AXIS_DATA_tdata;
   end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Self-checking bench for ofdm_cp_inserter: two instances (CP_LEN=2 and CP_LEN=0)
// selected by sel, with a scoreboard of expected output beats and event pulses.
module tb_ofdm_cp_inserter;

   localparam int DW = 32;
   localparam int NF = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid, s_tlast, m_tready;

   logic          s_tready_a, m_tvalid_a, m_tlast_a, fs_a, tm_a, tu_a;
   logic [DW-1:0] m_tdata_a;
   logic          s_tready_b, m_tvalid_b, m_tlast_b, fs_b, tm_b, tu_b;
   logic [DW-1:0] m_tdata_b;

   logic          s_tready, m_tvalid, m_tlast, ev_fs, ev_tm, ev_tu;
   logic [DW-1:0] m_tdata;

   always #5 clk = ~clk;

   ofdm_cp_inserter #(.DATA_W(DW), .NFFT(NF), .CP_LEN(2)) dut (
      .aclk(clk), .areset(rst),
      .S_AXIS_DATA_tdata(s_tdata), .S_AXIS_DATA_tvalid(s_tvalid & ~sel),
      .S_AXIS_DATA_tlast(s_tlast), .S_AXIS_DATA_tready(s_tready_a),
      .M_AXIS_DATA_tdata(m_tdata_a), .M_AXIS_DATA_tvalid(m_tvalid_a),
      .M_AXIS_DATA_tlast(m_tlast_a), .M_AXIS_DATA_tready(m_tready & ~sel),
      .event_frame_started(fs_a), .event_tlast_missing(tm_a),
      .event_tlast_unexpected(tu_a));

   ofdm_cp_inserter #(.DATA_W(DW), .NFFT(NF), .CP_LEN(0)) dut0 (
      .aclk(clk), .areset(rst),
      .S_AXIS_DATA_tdata(s_tdata), .S_AXIS_DATA_tvalid(s_tvalid & sel),
      .S_AXIS_DATA_tlast(s_tlast), .S_AXIS_DATA_tready(s_tready_b),
      .M_AXIS_DATA_tdata(m_tdata_b), .M_AXIS_DATA_tvalid(m_tvalid_b),
      .M_AXIS_DATA_tlast(m_tlast_b), .M_AXIS_DATA_tready(m_tready & sel),
      .event_frame_started(fs_b), .event_tlast_missing(tm_b),
      .event_tlast_unexpected(tu_b));

   assign s_tready = sel ? s_tready_b : s_tready_a;
   assign m_tvalid = sel ? m_tvalid_b : m_tvalid_a;
   assign m_tlast  = sel ? m_tlast_b  : m_tlast_a;
   assign m_tdata  = sel ? m_tdata_b  : m_tdata_a;
   assign ev_fs    = sel ? fs_b : fs_a;
   assign ev_tm    = sel ? tm_b : tm_a;
   assign ev_tu    = sel ? tu_b : tu_a;

   int n_assert = 0;
   int n_fail   = 0;

   // Stimulus and scoreboard
   logic [DW-1:0] in_data[$];
   bit            in_last[$];
   logic [DW:0]   sbq[$];
   logic [DW-1:0] model_buf [NF];
   int            model_cnt = 0;
   int            n_out, n_fs, n_tm, n_tu;
   bit            saw_tready_hi_in_emit;

   task automatic push_frame();
      int cp;
      cp = sel ? 0 : 2;
      for (int j = NF - cp; j < NF; j++) sbq.push_back({1'b0, model_buf[j]});
      for (int j = 0; j < NF; j++) sbq.push_back({(j == NF - 1), model_buf[j]});
   endtask

   task automatic run_stream(input int gap_mode, input int rdy_mode, input int abort_beat);
      int  idx, pops, cyc;
      bit  p_fs, p_tm, p_tu;
      logic [DW:0] exp;
      idx = 0; pops = 0; cyc = 0;
      p_fs = 0; p_tm = 0; p_tu = 0;
      n_out = 0; n_fs = 0; n_tm = 0; n_tu = 0;
      saw_tready_hi_in_emit = 0;
      while ((idx < in_data.size() || sbq.size() != 0 || p_fs || p_tm || p_tu) && cyc < 2000) begin
         @(negedge clk);
         n_assert++;
         if ({ev_fs, ev_tm, ev_tu} !== {p_fs, p_tm, p_tu}) begin
            n_fail++;
            $display("FAIL events cyc=%0d: got fs/tm/tu=%b%b%b want %b%b%b",
                     cyc, ev_fs, ev_tm, ev_tu, p_fs, p_tm, p_tu);
         end
         n_fs += int'(ev_fs); n_tm += int'(ev_tm); n_tu += int'(ev_tu);
         p_fs = 0; p_tm = 0; p_tu = 0;
         n_assert++;
         if (s_tready !== (sbq.size() == 0) || m_tvalid !== (sbq.size() != 0)) begin
            n_fail++;
            $display("FAIL handshake cyc=%0d: got s_tready=%b m_tvalid=%b want %b %b",
                     cyc, s_tready, m_tvalid, sbq.size() == 0, sbq.size() != 0);
         end
         if (sbq.size() != 0 && s_tready === 1'b1) saw_tready_hi_in_emit = 1;
         if (m_tvalid === 1'b1 && sbq.size() != 0) begin
            exp = sbq[0];
            n_assert++;
            if ({m_tlast, m_tdata} !== exp) begin
               n_fail++;
               $display("FAIL beat %0d: got data=%0d last=%b want data=%0d last=%b",
                        pops, m_tdata, m_tlast, exp[DW-1:0], exp[DW]);
            end
            if (abort_beat >= 0 && pops == abort_beat) begin
               rst = 1'b1;
               #1;
               n_assert++;
               if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || m_tlast !== 1'b0) begin
                  n_fail++;
                  $display("FAIL async_reset: got m_tvalid=%b s_tready=%b m_tlast=%b want 0 1 0",
                           m_tvalid, s_tready, m_tlast);
               end
               sbq.delete();
               model_cnt = 0;
               s_tvalid  = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               return;
            end
         end
         m_tready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
         if (m_tvalid === 1'b1 && m_tready && sbq.size() != 0) begin
            void'(sbq.pop_front());
            pops++;
            n_out++;
         end
         if (idx < in_data.size() && !(gap_mode != 0 && cyc % 3 == 2)) begin
            s_tvalid = 1'b1;
            s_tdata  = in_data[idx];
            s_tlast  = in_last[idx];
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         if (s_tvalid && s_tready === 1'b1) begin
            p_fs = (model_cnt == 0);
            model_buf[model_cnt] = s_tdata;
            if (model_cnt == NF - 1) begin
               p_tm = !s_tlast;
               model_cnt = 0;
               push_frame();
            end else if (s_tlast) begin
               p_tu = 1;
               model_cnt = 0;
            end else begin
               model_cnt++;
            end
            idx++;
         end
         cyc++;
      end
      if (cyc >= 2000) begin
         n_assert++;
         n_fail++;
         $display("FAIL timeout: got %0d cycles with %0d beats pending, want completion", cyc, sbq.size());
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic load_frame(input int base, input int len, input int last_pos);
      for (int i = 0; i < len; i++) begin
         in_data.push_back(DW'(base + i));
         in_last.push_back(i == last_pos);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 1'b0;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         sel = (k == 1);
         #1;
         n_assert++;
         if ({s_tready, m_tvalid, m_tlast, ev_fs, ev_tm, ev_tu} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d: got tready/tvalid/tlast/ev=%b want 100000",
                     k, {s_tready, m_tvalid, m_tlast, ev_fs, ev_tm, ev_tu});
         end
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_cnt = 0;
   endtask

   task automatic test_basic();
      in_data.delete(); in_last.delete();
      load_frame(0, NF, NF - 1);
      run_stream(0, 0, -1);
      n_assert++;
      if (n_out !== 10 || n_fs !== 1 || n_tm !== 0 || n_tu !== 0) begin
         n_fail++;
         $display("FAIL basic_counts: got out=%0d fs=%0d tm=%0d tu=%0d want 10 1 0 0", n_out, n_fs, n_tm, n_tu);
      end
   endtask

   task automatic test_backpressure();
      in_data.delete(); in_last.delete();
      load_frame(0, NF, NF - 1);
      run_stream(1, 1, -1);
      n_assert++;
      if (n_out !== 10 || saw_tready_hi_in_emit !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure: got out=%0d tready_in_emit=%b want 10 0", n_out, saw_tready_hi_in_emit);
      end
   endtask

   task automatic test_tlast_unexpected();
      in_data.delete(); in_last.delete();
      load_frame(0, 5, 4);
      load_frame(10, NF, NF - 1);
      run_stream(0, 0, -1);
      n_assert++;
      if (n_out !== 10 || n_tu !== 1 || n_fs !== 2) begin
         n_fail++;
         $display("FAIL tlast_unexpected: got out=%0d tu=%0d fs=%0d want 10 1 2", n_out, n_tu, n_fs);
      end
   endtask

   task automatic test_tlast_missing();
      in_data.delete(); in_last.delete();
      load_frame(0, NF, -1);
      run_stream(0, 0, -1);
      n_assert++;
      if (n_out !== 10 || n_tm !== 1) begin
         n_fail++;
         $display("FAIL tlast_missing: got out=%0d tm=%0d want 10 1", n_out, n_tm);
      end
   endtask

   task automatic test_cp_zero();
      sel = 1'b1;
      in_data.delete(); in_last.delete();
      load_frame(0, NF, NF - 1);
      run_stream(0, 0, -1);
      n_assert++;
      if (n_out !== NF || n_fs !== 1) begin
         n_fail++;
         $display("FAIL cp_zero: got out=%0d fs=%0d want 8 1", n_out, n_fs);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      in_data.delete(); in_last.delete();
      load_frame(50, NF, NF - 1);
      run_stream(0, 0, 3);
      in_data.delete(); in_last.delete();
      load_frame(20, NF, NF - 1);
      run_stream(0, 0, -1);
      n_assert++;
      if (n_out !== 10 || n_fs !== 1) begin
         n_fail++;
         $display("FAIL reset_recovery: got out=%0d fs=%0d want 10 1", n_out, n_fs);
      end
   endtask

   task automatic test_back_to_back();
      in_data.delete(); in_last.delete();
      load_frame(30, NF, NF - 1);
      load_frame(40, NF, NF - 1);
      run_stream(0, 1, -1);
      n_assert++;
      if (n_out !== 20 || n_fs !== 2) begin
         n_fail++;
         $display("FAIL back_to_back: got out=%0d fs=%0d want 20 2", n_out, n_fs);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_tlast_unexpected();
      test_tlast_missing();
      test_cp_zero();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
